// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: button-sequenced ALU front end. Operand A, operand B and the
// opcode are latched from the switches by synchronised, edge-detected button
// pulses in a fixed order; one ALU operation is then executed and its result
// and status flags are registered onto the LED outputs.
module alu_seq_ctrl #(
    parameter int NB_DATA  = 8,
    parameter int NB_OP    = 6,
    parameter int NB_SHAMT = $clog2(NB_DATA)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [2:0]         i_buttons,
    input  logic [NB_DATA-1:0] i_switches,
    output logic [NB_DATA-1:0] o_leds,
    output logic               o_valid,
    output logic               o_zero,
    output logic               o_carry,
    output logic               o_overflow,
    output logic               o_error,
    output logic [1:0]         o_state
);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        EXEC    = 2'd3
    } state_t;

    // MIPS funct encodings
    localparam logic [NB_OP-1:0] OP_SLL  = NB_OP'(0);
    localparam logic [NB_OP-1:0] OP_SRL  = NB_OP'(2);
    localparam logic [NB_OP-1:0] OP_SRA  = NB_OP'(3);
    localparam logic [NB_OP-1:0] OP_ADD  = NB_OP'(32);
    localparam logic [NB_OP-1:0] OP_SUB  = NB_OP'(34);
    localparam logic [NB_OP-1:0] OP_AND  = NB_OP'(36);
    localparam logic [NB_OP-1:0] OP_OR   = NB_OP'(37);
    localparam logic [NB_OP-1:0] OP_XOR  = NB_OP'(38);
    localparam logic [NB_OP-1:0] OP_NOR  = NB_OP'(39);
    localparam logic [NB_OP-1:0] OP_SLT  = NB_OP'(42);
    localparam logic [NB_OP-1:0] OP_SLTU = NB_OP'(43);

    localparam int MSB = NB_DATA - 1;

    typedef struct packed {
        logic [NB_DATA-1:0] result;
        logic               carry;
        logic               overflow;
        logic               error;
    } alu_out_t;

    // Single ALU evaluation; unsupported opcodes yield result 0 with error set.
    function automatic alu_out_t alu_eval(
        input logic [NB_DATA-1:0] a,
        input logic [NB_DATA-1:0] b,
        input logic [NB_OP-1:0]   op
    );
        alu_out_t                  r;
        logic        [NB_DATA:0]   wide;
        logic        [NB_SHAMT-1:0] shamt;
        logic signed [NB_DATA-1:0] sa;
        logic signed [NB_DATA-1:0] sb;
        r     = '0;
        wide  = '0;
        shamt = b[NB_SHAMT-1:0];
        sa    = a;
        sb    = b;
        case (op)
            OP_SLL:  r.result = a << shamt;
            OP_SRL:  r.result = a >> shamt;
            OP_SRA:  r.result = $unsigned(sa >>> shamt);
            OP_ADD: begin
                wide       = {1'b0, a} + {1'b0, b};
                r.result   = wide[NB_DATA-1:0];
                r.carry    = wide[NB_DATA];
                r.overflow = (a[MSB] == b[MSB]) && (wide[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // zero-extended subtraction: top bit is the borrow (A < B unsigned)
                wide       = {1'b0, a} - {1'b0, b};
                r.result   = wide[NB_DATA-1:0];
                r.carry    = wide[NB_DATA];
                r.overflow = (a[MSB] != b[MSB]) && (wide[MSB] != a[MSB]);
            end
            OP_AND:  r.result = a & b;
            OP_OR:   r.result = a | b;
            OP_XOR:  r.result = a ^ b;
            OP_NOR:  r.result = ~(a | b);
            OP_SLT:  r.result = {{(NB_DATA-1){1'b0}}, (sa < sb)};
            OP_SLTU: r.result = {{(NB_DATA-1){1'b0}}, (a < b)};
            default: r.error  = 1'b1;
        endcase
        return r;
    endfunction

    state_t             state;
    state_t             state_next;
    logic [2:0]         sync_p0;
    logic [2:0]         sync_p1;
    logic [2:0]         sync_p2;
    logic [2:0]         pulse;
    logic               load_a;
    logic               load_b;
    logic               load_op;
    logic [NB_DATA-1:0] opa;
    logic [NB_DATA-1:0] opb;
    logic [NB_OP-1:0]   opcode;
    alu_out_t           alu_p0;

    // Two-flop synchroniser plus one delay flop for rising-edge detection
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
        end else begin
            sync_p0 <= i_buttons;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    // ---- stage p0: synchronised edge pulses and FSM decisions ----
    assign pulse = sync_p1 & ~sync_p2;

    // FSM state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // Next state and latch enables; only the pulse expected in the current state acts
    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        case (state)
            WAIT_A: if (pulse[0]) begin
                load_a     = 1'b1;
                state_next = WAIT_B;
            end
            WAIT_B: if (pulse[1]) begin
                load_b     = 1'b1;
                state_next = WAIT_OP;
            end
            WAIT_OP: if (pulse[2]) begin
                load_op    = 1'b1;
                state_next = EXEC;
            end
            EXEC:    state_next = WAIT_A;
            default: state_next = WAIT_A;
        endcase
    end

    // Operand and opcode latches
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            opa    <= '0;
            opb    <= '0;
            opcode <= '0;
        end else begin
            if (load_a)  opa    <= i_switches;
            if (load_b)  opb    <= i_switches;
            if (load_op) opcode <= i_switches[NB_OP-1:0];
        end
    end

    assign alu_p0 = alu_eval(opa, opb, opcode);

    // ---- stage p1: registered result and flags ----
    // Result and flags capture at the edge closing EXEC and hold until the next one
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_leds     <= '0;
            o_zero     <= 1'b0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
            o_error    <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            o_valid <= (state == EXEC);
            if (state == EXEC) begin
                o_leds     <= alu_p0.result;
                o_zero     <= !alu_p0.error && (alu_p0.result == '0);
                o_carry    <= alu_p0.carry;
                o_overflow <= alu_p0.overflow;
                o_error    <= alu_p0.error;
            end
        end
    end

    assign o_state = state;

endmodule
